// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
// Holds the op encodings, the FSM state encoding and the default width.
package ex_mdu_pkg;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_MULLO = 2'b00,
    OP_MULHI = 2'b01,
    OP_DIVQ  = 2'b10,
    OP_DIVR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_e;
endpackage

// File: rtl/ex_mdu_dp.sv
// Datapath for ex_mdu_seq: shift/accumulate registers plus adder/subtractor.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   load           capture operands (a, b) for a new operation
//   step           perform one shift-add (mul) or restoring shift-subtract (div)
//   is_div         selects divide mode for load/step
//   a, b           operands (multiplicand/dividend, multiplier/divisor)
//   prod_nxt       product after the current step (2*WIDTH)
//   quo_nxt        quotient after the current step
//   rem_nxt        remainder after the current step
//   mpl_zero_nxt   remaining multiplier bits are zero after the current step
module ex_mdu_dp #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod_nxt,
  output logic [WIDTH-1:0]   quo_nxt,
  output logic [WIDTH-1:0]   rem_nxt,
  output logic               mpl_zero_nxt
);
  // mcand: shifted multiplicand (mul) or divisor in low half (div)
  // sh:    multiplier shifting right (mul) or dividend/quotient shifting left (div)
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   sh, rem;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   diff;
  logic               ge;

  // Multiplicand is shifted left rather than the accumulator right, so the
  // product stays aligned if the multiply stops early.
  assign prod_nxt     = acc + (sh[0] ? mcand : '0);
  assign mpl_zero_nxt = (sh[WIDTH-1:1] == '0);

  // Remainder stays below the divisor, so the low WIDTH bits of the
  // difference are exact whenever the subtraction is taken.
  assign trial   = {rem, sh[WIDTH-1]};
  assign ge      = trial >= {1'b0, mcand[WIDTH-1:0]};
  assign diff    = trial[WIDTH-1:0] - mcand[WIDTH-1:0];
  assign rem_nxt = ge ? diff : trial[WIDTH-1:0];
  assign quo_nxt = {sh[WIDTH-2:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      sh    <= '0;
      rem   <= '0;
    end else if (load) begin
      acc   <= '0;
      rem   <= '0;
      sh    <= is_div ? a : b;
      mcand <= {{WIDTH{1'b0}}, (is_div ? b : a)};
    end else if (step) begin
      if (is_div) begin
        rem <= rem_nxt;
        sh  <= quo_nxt;
      end else begin
        acc   <= prod_nxt;
        mcand <= mcand << 1;
        sh    <= sh >> 1;
      end
    end
  end
endmodule

// File: rtl/ex_mdu_seq.sv
// Sequential unsigned multiply/divide unit for the execute stage.
// One shift-add / shift-subtract step per cycle; done pulses with the result.
// Optional macro EX_MDU_EARLY_OUT_EN: multiply finishes once the remaining
// multiplier bits are all zero.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        request a new operation (accepted in IDLE or DONE)
//   op           00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR
//   opA, opB     operands, sampled on accepted start
//   flush        abort any in-flight operation
//   stall        hold the front of the pipe while busy
//   done         one-cycle result-valid pulse
//   result       selected product half, quotient or remainder
//   divZero      divisor was zero (qualified by done)
module ex_mdu_seq
  import ex_mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             divZero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state;
  op_e              op_q;
  logic [CW-1:0]    cnt;
  logic             accept, last, dp_div, mul_end;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;
  logic             mpl_zero_nxt;

  assign accept = start && !flush && (state == S_IDLE || state == S_DONE);
  assign last   = (cnt == CW'(WIDTH-1));
  assign dp_div = accept ? op[1] : op_q[1];
  assign stall  = rst_n && (start || state == S_MUL || state == S_DIV);

`ifdef EX_MDU_EARLY_OUT_EN
  assign mul_end = last || mpl_zero_nxt;
`else
  assign mul_end = last;
`endif

  ex_mdu_dp #(.WIDTH(WIDTH)) u_dp (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept),
    .step         (state == S_MUL || state == S_DIV),
    .is_div       (dp_div),
    .a            (opA),
    .b            (opB),
    .prod_nxt     (prod_nxt),
    .quo_nxt      (quo_nxt),
    .rem_nxt      (rem_nxt),
    .mpl_zero_nxt (mpl_zero_nxt)
  );

  // done/divZero are registered alongside the transition into DONE, so they
  // are high exactly while state==DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= OP_MULLO;
      cnt     <= '0;
      result  <= '0;
      done    <= 1'b0;
      divZero <= 1'b0;
    end else begin
      done    <= 1'b0;
      divZero <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            state <= S_IDLE;
            if (start) begin
              op_q <= op_e'(op);
              cnt  <= '0;
              if (op[1] && opB == '0) begin
                state   <= S_DONE;
                done    <= 1'b1;
                divZero <= 1'b1;
                result  <= op[0] ? opA : '1;
`ifdef EX_MDU_EARLY_OUT_EN
              end else if (!op[1] && opB == '0) begin
                state  <= S_DONE;
                done   <= 1'b1;
                result <= '0;
`endif
              end else begin
                state <= op[1] ? S_DIV : S_MUL;
              end
            end
          end
          S_MUL: begin
            cnt <= cnt + 1'b1;
            if (mul_end) begin
              state  <= S_DONE;
              done   <= 1'b1;
              cnt    <= '0;
              result <= op_q[0] ? prod_nxt[2*WIDTH-1:WIDTH] : prod_nxt[WIDTH-1:0];
            end
          end
          S_DIV: begin
            cnt <= cnt + 1'b1;
            if (last) begin
              state  <= S_DONE;
              done   <= 1'b1;
              cnt    <= '0;
              result <= op_q[0] ? rem_nxt : quo_nxt;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/ex_mdu_seq.md
EX_MDU_SEQ -- requirements
Module: ex_mdu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width in bits (16 for the ISA datapath).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start  input  1  single-cycle request from the execute stage to begin an operation.
REQ-005 SHALL have port op  input  2  operation: 00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR (all unsigned).
REQ-006 SHALL have port opA  input  WIDTH  multiplicand/dividend, sampled only with an accepted start.
REQ-007 SHALL have port opB  input  WIDTH  multiplier/divisor, sampled only with an accepted start.
REQ-008 SHALL have port flush  input  1  pipeline flush; aborts any in-flight operation.
REQ-009 SHALL have port stall  output  1  holds IF/ID/EX stages while an operation is in flight.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid in the same cycle.
REQ-011 SHALL have port result  output  WIDTH  selected product half, quotient or remainder.
REQ-012 SHALL have port divZero  output  1  qualified by done; divisor was zero.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start in MUL/DIV is ignored.
REQ-015 SHALL latch opA, opB, op on accepted start and enter MUL (op[1]=0) or DIV (op[1]=1).
REQ-016 SHALL perform one shift-add (MUL) or one restoring shift-subtract (DIV) step per cycle; exactly WIDTH cycles in MUL/DIV, then DONE.
REQ-017 SHALL assert done and drive result for exactly one cycle in DONE, then return to IDLE (or to MUL/DIV if start is accepted in that cycle).
REQ-018 SHALL produce a 2*WIDTH product internally; MULLO returns [WIDTH-1:0], MULHI returns [2*WIDTH-1:WIDTH].
REQ-019 SHALL, on divisor zero, skip DIV and enter DONE next cycle with divZero=1, DIVQ result all-ones, DIVR result = opA.
REQ-020 SHALL drive stall = start | (state==MUL) | (state==DIV), combinationally; stall deasserts in the DONE cycle.
REQ-021 SHALL, on flush in any state, enter IDLE next cycle with no done pulse; flush and start in the same cycle: flush wins, start discarded.
REQ-022 SHALL hold result at its last DONE value in IDLE; done and divZero SHALL be 0 outside DONE.
REQ-023 SHALL latency: start to done = WIDTH+1 cycles (17 at WIDTH=16), divide-by-zero = 1 cycle, unless REQ-028 applies.

Reset
REQ-024 SHALL on rst_n low asynchronously force state IDLE, step counter 0, result 0, done 0, divZero 0.
REQ-025 SHALL, while rst_n is low, drive stall = 0 regardless of start.
REQ-026 SHALL abandon any in-flight operation when reset asserts mid-operation; no done after release.

Configuration
REQ-027 SHALL compile early termination only when macro EX_MDU_EARLY_OUT_EN is defined.
REQ-028 With EX_MDU_EARLY_OUT_EN: MUL SHALL enter DONE the cycle after remaining multiplier bits are all zero (opB=0 gives done 1 cycle after start); DIV unaffected.
REQ-029 Without EX_MDU_EARLY_OUT_EN: MUL SHALL always take exactly WIDTH cycles.

Structure
REQ-030 SHALL place op encodings (MULLO/MULHI/DIVQ/DIVR), FSM state encoding, and default WIDTH in shared package ex_mdu_pkg.
REQ-031 SHALL split the shift/accumulate registers and adder/subtractor into one sub-module ex_mdu_dp; ex_mdu_seq holds FSM, counter, handshake.

Verification
REQ-032 MULLO 16'h00FF x 16'h0101 -> stall 16 cycles, done at cycle 17, result 16'hFFFF.
REQ-033 MULHI 16'hFFFF x 16'hFFFF -> result 16'hFFFE; DIVQ 16'd100 / 16'd7 -> 16'd14; DIVR same -> 16'd2.
REQ-034 DIVQ 16'h1234 / 0 -> done 1 cycle after start, divZero=1, result 16'hFFFF; DIVR -> 16'h1234.
REQ-035 Start DIVQ, flush at cycle 5 -> IDLE next cycle, no done, stall 0; new start accepted immediately.
REQ-036 Back-to-back: start asserted in DONE cycle -> second op accepted, stall reasserts, second done 17 cycles later.
REQ-037 rst_n low at cycle 8 of MUL -> outputs zero immediately, no done after release; with EX_MDU_EARLY_OUT_EN, MULLO 16'h1234 x 16'h0003 -> done at cycle 3, result 16'h369C.
